// File: rtl/packetgen_pkg.sv
// Shared Ethernet framing constants for the traffic generator and packet checker.
package packetgen_pkg;

   localparam int ETH_HDR_BYTES = 14;
   localparam int OFF_DMAC      = 0;
   localparam int OFF_SMAC      = 6;
   localparam int OFF_ETYPE     = 12;
   localparam int OFF_PAYLOAD   = 14;

   typedef enum logic [0:0] {
      S_HDR  = 1'b0,
      S_BODY = 1'b1
   } chk_state_t;

   // Flow index width; a single flow still needs a 1-bit index port.
   function automatic int flow_w(input int n_flows);
      return (n_flows > 1) ? $clog2(n_flows) : 1;
   endfunction

endpackage

// File: rtl/packet_checker_beat_checker.sv
// Per-beat combinational checks: enabled-byte count, payload fill mismatch, tkeep shape.
module beat_checker
   import packetgen_pkg::*;
#(
   parameter int DATA_WIDTH = 512
)(
   input  logic [DATA_WIDTH-1:0]          i_tdata,
   input  logic [DATA_WIDTH/8-1:0]        i_tkeep,
   input  logic [7:0]                     i_exp_byte,
   input  logic                           i_is_hdr,
   input  logic                           i_is_last,
   output logic [$clog2(DATA_WIDTH/8):0]  o_popcnt,
   output logic                           o_pay_err,
   output logic                           o_keep_err
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int CW    = $clog2(BYTES) + 1;

   logic [BYTES-1:0] w_bad;
   logic [BYTES-1:0] w_keep_inc;

   genvar gi;
   generate
      for (gi = 0; gi < BYTES; gi++) begin : g_byte
         if (gi < OFF_PAYLOAD) begin : g_hdr_pos
            // Header positions only carry payload on continuation beats.
            assign w_bad[gi] = i_tkeep[gi] && !i_is_hdr &&
                               (i_tdata[8*gi +: 8] != i_exp_byte);
         end else begin : g_pay_pos
            assign w_bad[gi] = i_tkeep[gi] && (i_tdata[8*gi +: 8] != i_exp_byte);
         end
      end
   endgenerate

   always_comb begin
      o_popcnt = '0;
      for (int k = 0; k < BYTES; k++) begin
         o_popcnt = o_popcnt + {{(CW-1){1'b0}}, i_tkeep[k]};
      end
   end

   assign o_pay_err  = |w_bad;
   assign w_keep_inc = i_tkeep + {{(BYTES-1){1'b0}}, 1'b1};

   // A keep of the form 0..01..1 has no overlap with itself plus one.
   always_comb begin
      o_keep_err = 1'b0;
      if (!i_is_hdr) begin
         if (!i_is_last) o_keep_err = (i_tkeep != {BYTES{1'b1}});
         else            o_keep_err = ((i_tkeep & w_keep_inc) != '0);
      end
   end

endmodule

// File: rtl/packet_checker.sv
// AXI Stream Ethernet sink: classifies frames by dest MAC, checks them per flow, counts results.
module packet_checker
   import packetgen_pkg::*;
#(
   parameter int                    DATA_WIDTH = 512,
   parameter int                    N_FLOWS    = 4,
   parameter logic [11*N_FLOWS-1:0] SIZES      = {11'd128, 11'd192, 11'd64, 11'd192},
   parameter logic [48*N_FLOWS-1:0] D_MACS     = {48'hABCDEF000007, 48'hABCDEF000006,
                                                  48'hABCDEF000005, 48'hABCDEF000004},
   parameter logic [48*N_FLOWS-1:0] S_MACS     = {48'hBEEFBEEF0007, 48'hBEEFBEEF0006,
                                                  48'hBEEFBEEF0005, 48'hBEEFBEEF0004},
   parameter logic [16*N_FLOWS-1:0] ETHERTYPES = {16'h88B5, 16'h0806, 16'h86DD, 16'h0800},
   parameter logic [8*N_FLOWS-1:0]  PAYLOADS   = {8'h44, 8'h3C, 8'h5A, 8'hDD}
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          axis_tvalid,
   output logic                          axis_tready,
   input  logic                          axis_tlast,
   input  logic [DATA_WIDTH/8-1:0]       axis_tkeep,
   input  logic [DATA_WIDTH-1:0]         axis_tdata,
   input  logic                          clear,
   output logic [32*N_FLOWS-1:0]         rx_pkts,
   output logic [48*N_FLOWS-1:0]         rx_bytes,
   output logic [32*N_FLOWS-1:0]         rx_errs,
   output logic [31:0]                   unknown_pkts,
   output logic                          evt_valid,
   output logic [flow_w(N_FLOWS)-1:0]    evt_flow,
   output logic                          evt_ok,
   output logic                          evt_known
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int CW    = $clog2(BYTES) + 1;
   localparam int FW    = flow_w(N_FLOWS);

   chk_state_t        r_state;
   logic [FW-1:0]     r_flow;
   logic              r_known;
   logic              r_err;
   logic [11:0]       r_len;
   logic              r_evt_valid, r_evt_ok, r_evt_known;
   logic [FW-1:0]     r_evt_flow;
   logic [31:0]       r_unknown;

   logic [47:0]       w_dmac, w_smac;
   logic [15:0]       w_etype;
   logic [N_FLOWS-1:0] w_match;
   logic [FW-1:0]     w_hit_flow, w_flow;
   logic              w_hit_known, w_is_hdr;
   logic [7:0]        w_exp_byte;
   logic [CW-1:0]     w_cnt;
   logic              w_pay_err, w_keep_err, w_hdr_err;
   logic [12:0]       w_len_sum;
   logic [11:0]       w_len;
   logic              w_err_now, w_known_now, w_runt;
   logic              w_fin, w_fin_known, w_fin_ok;

   assign axis_tready = !rst;
   assign w_is_hdr    = (r_state == S_HDR);

   // Header fields are big-endian on the wire: lowest byte lane is the MSB.
   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_mac
         assign w_dmac[47-8*gi -: 8] = axis_tdata[8*(OFF_DMAC+gi) +: 8];
         assign w_smac[47-8*gi -: 8] = axis_tdata[8*(OFF_SMAC+gi) +: 8];
      end
      for (gi = 0; gi < 2; gi++) begin : g_etype
         assign w_etype[15-8*gi -: 8] = axis_tdata[8*(OFF_ETYPE+gi) +: 8];
      end
      for (gi = 0; gi < N_FLOWS; gi++) begin : g_match
         assign w_match[gi] = (w_dmac == D_MACS[48*gi +: 48]);
      end
   endgenerate

   always_comb begin
      w_hit_known = 1'b0;
      w_hit_flow  = '0;
      for (int f = N_FLOWS - 1; f >= 0; f--) begin
         if (w_match[f]) begin
            w_hit_known = 1'b1;
            w_hit_flow  = FW'(f);
         end
      end
   end

   // Unknown frames resolve to flow 0 so checks run on defined values.
   assign w_flow      = w_is_hdr ? w_hit_flow : r_flow;
   assign w_known_now = w_is_hdr ? w_hit_known : r_known;
   assign w_exp_byte  = PAYLOADS[8*int'(w_flow) +: 8];
   assign w_hdr_err   = (w_smac != S_MACS[48*int'(w_flow) +: 48]) ||
                        (w_etype != ETHERTYPES[16*int'(w_flow) +: 16]);

   beat_checker #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_beat (
      .i_tdata    (axis_tdata),
      .i_tkeep    (axis_tkeep),
      .i_exp_byte (w_exp_byte),
      .i_is_hdr   (w_is_hdr),
      .i_is_last  (axis_tlast),
      .o_popcnt   (w_cnt),
      .o_pay_err  (w_pay_err),
      .o_keep_err (w_keep_err)
   );

   assign w_len_sum   = w_is_hdr ? 13'(w_cnt) : ({1'b0, r_len} + 13'(w_cnt));
   assign w_len       = w_len_sum[12] ? 12'hFFF : w_len_sum[11:0];
   assign w_err_now   = (w_is_hdr ? w_hdr_err : r_err) | w_pay_err | w_keep_err;
   assign w_runt      = w_is_hdr && !(&axis_tkeep[ETH_HDR_BYTES-1:0]);
   assign w_fin       = axis_tvalid && axis_tlast;
   assign w_fin_known = w_known_now && !w_runt;
   assign w_fin_ok    = w_fin_known && !w_err_now &&
                        (w_len == {1'b0, SIZES[11*int'(w_flow) +: 11]});

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_HDR;
         r_flow      <= '0;
         r_known     <= 1'b0;
         r_err       <= 1'b0;
         r_len       <= '0;
         r_evt_valid <= 1'b0;
         r_evt_flow  <= '0;
         r_evt_ok    <= 1'b0;
         r_evt_known <= 1'b0;
      end else begin
         r_evt_valid <= w_fin;
         r_evt_flow  <= (w_fin && w_fin_known) ? w_flow : '0;
         r_evt_ok    <= w_fin && w_fin_ok;
         r_evt_known <= w_fin && w_fin_known;
         if (axis_tvalid) begin
            if (axis_tlast) begin
               r_state <= S_HDR;
            end else begin
               r_state <= S_BODY;
               r_flow  <= w_flow;
               r_known <= w_known_now;
               r_err   <= w_err_now;
               r_len   <= w_len;
            end
         end
      end
   end

   assign evt_valid = r_evt_valid;
   assign evt_flow  = r_evt_flow;
   assign evt_ok    = r_evt_ok;
   assign evt_known = r_evt_known;

   generate
      for (gi = 0; gi < N_FLOWS; gi++) begin : g_cnt
         logic [31:0] r_pkts, r_errs;
         logic [47:0] r_bytes;
         logic [48:0] w_bsum;
         logic        w_hit;

         assign w_hit  = w_fin && w_fin_known && (w_flow == FW'(gi));
         assign w_bsum = {1'b0, r_bytes} + 49'(w_len);

         always_ff @(posedge clk) begin
            if (rst || clear) begin
               r_pkts  <= '0;
               r_errs  <= '0;
               r_bytes <= '0;
            end else if (w_hit) begin
               if (w_fin_ok) begin
                  if (r_pkts != '1) r_pkts <= r_pkts + 32'd1;
                  r_bytes <= w_bsum[48] ? '1 : w_bsum[47:0];
               end else if (r_errs != '1) begin
                  r_errs <= r_errs + 32'd1;
               end
            end
         end

         assign rx_pkts[32*gi +: 32]  = r_pkts;
         assign rx_errs[32*gi +: 32]  = r_errs;
         assign rx_bytes[48*gi +: 48] = r_bytes;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst || clear)
         r_unknown <= '0;
      else if (w_fin && !w_fin_known && (r_unknown != '1))
         r_unknown <= r_unknown + 32'd1;
   end

   assign unknown_pkts = r_unknown;

endmodule

// File: tb/tb_packet_checker.sv
// Directed bench for packet_checker: frames built from flow tables, events scoreboarded in order.
module tb_packet_checker;

   localparam int DW = 512;
   localparam int NB = DW / 8;

   localparam logic [47:0] DM [4] = '{48'hABCDEF000004, 48'hABCDEF000005,
                                      48'hABCDEF000006, 48'hABCDEF000007};
   localparam logic [47:0] SM [4] = '{48'hBEEFBEEF0004, 48'hBEEFBEEF0005,
                                      48'hBEEFBEEF0006, 48'hBEEFBEEF0007};
   localparam logic [15:0] ET [4] = '{16'h0800, 16'h86DD, 16'h0806, 16'h88B5};
   localparam logic [7:0]  PL [4] = '{8'hDD, 8'h5A, 8'h3C, 8'h44};
   localparam int          SZ [4] = '{192, 64, 192, 128};

   logic            clk = 1'b0;
   logic            rst;
   logic            axis_tvalid, axis_tready, axis_tlast, clear;
   logic [NB-1:0]   axis_tkeep;
   logic [DW-1:0]   axis_tdata;
   logic [127:0]    rx_pkts, rx_errs;
   logic [191:0]    rx_bytes;
   logic [31:0]     unknown_pkts;
   logic            evt_valid, evt_ok, evt_known;
   logic [1:0]      evt_flow;

   packet_checker #(
      .DATA_WIDTH (DW),
      .N_FLOWS    (4),
      .SIZES      ({11'(SZ[3]), 11'(SZ[2]), 11'(SZ[1]), 11'(SZ[0])}),
      .D_MACS     ({DM[3], DM[2], DM[1], DM[0]}),
      .S_MACS     ({SM[3], SM[2], SM[1], SM[0]}),
      .ETHERTYPES ({ET[3], ET[2], ET[1], ET[0]}),
      .PAYLOADS   ({PL[3], PL[2], PL[1], PL[0]})
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .axis_tvalid  (axis_tvalid),
      .axis_tready  (axis_tready),
      .axis_tlast   (axis_tlast),
      .axis_tkeep   (axis_tkeep),
      .axis_tdata   (axis_tdata),
      .clear        (clear),
      .rx_pkts      (rx_pkts),
      .rx_bytes     (rx_bytes),
      .rx_errs      (rx_errs),
      .unknown_pkts (unknown_pkts),
      .evt_valid    (evt_valid),
      .evt_flow     (evt_flow),
      .evt_ok       (evt_ok),
      .evt_known    (evt_known)
   );

   always #5 clk = ~clk;

   typedef struct {
      int flow;
      bit ok;
      bit known;
      int cyc;
   } ev_t;

   ev_t evq[$];
   int  cyc = 0;
   int  last_cyc = 0;
   int  n_chk = 0;
   int  n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (evt_valid === 1'b1)
         evq.push_back('{int'(evt_flow), evt_ok, evt_known, cyc});
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else begin
         n_pass++;
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] beat_data(input logic [47:0] dm, input logic [47:0] sm,
                                               input logic [15:0] et, input logic [7:0] fill,
                                               input int beat, input int bad);
      logic [DW-1:0] d;
      logic [7:0]    v;
      int            k;
      d = '0;
      for (int b = 0; b < NB; b++) begin
         k = beat * NB + b;
         if (k < 6)       v = dm[8*(5-k) +: 8];
         else if (k < 12) v = sm[8*(11-k) +: 8];
         else if (k < 14) v = et[8*(13-k) +: 8];
         else             v = fill;
         if (k == bad) v = 8'h00;
         d[8*b +: 8] = v;
      end
      return d;
   endfunction

   function automatic logic [NB-1:0] beat_keep(input int len, input int beat);
      logic [NB-1:0] kp;
      for (int b = 0; b < NB; b++) kp[b] = ((beat * NB + b) < len);
      return kp;
   endfunction

   task automatic send_frame(input logic [47:0] dm, input logic [47:0] sm, input logic [15:0] et,
                             input logic [7:0] fill, input int len, input int bad,
                             input bit clr_last, input bit hold);
      int nbeats;
      nbeats = (len + NB - 1) / NB;
      if (nbeats == 0) nbeats = 1;
      for (int b = 0; b < nbeats; b++) begin
         axis_tdata  = beat_data(dm, sm, et, fill, b, bad);
         axis_tkeep  = beat_keep(len, b);
         axis_tlast  = (b == nbeats - 1);
         axis_tvalid = 1'b1;
         clear       = clr_last && (b == nbeats - 1);
         tick();
      end
      last_cyc = cyc;
      clear    = 1'b0;
      if (!hold) begin
         axis_tvalid = 1'b0;
         axis_tlast  = 1'b0;
      end
   endtask

   task automatic expect_evt(input string tag, input int flow, input bit ok, input bit known,
                             input bit chk_lat);
      ev_t e;
      check({tag, "_present"}, 64'(evq.size() != 0), 64'd1);
      if (evq.size() != 0) begin
         e = evq.pop_front();
         check({tag, "_flow"}, 64'(e.flow), 64'(flow));
         check({tag, "_ok"}, 64'(e.ok), 64'(ok));
         check({tag, "_known"}, 64'(e.known), 64'(known));
         if (chk_lat) check({tag, "_lat"}, 64'(e.cyc), 64'(last_cyc));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      ev_t bb [4];
      rst = 1'b1; clear = 1'b0; axis_tvalid = 1'b0; axis_tlast = 1'b0;
      axis_tkeep = '0; axis_tdata = '0;
      repeat (3) tick();
      check("tready_in_rst", 64'(axis_tready), 64'd0);
      rst = 1'b0;
      #1;
      check("tready_after_rst", 64'(axis_tready), 64'd1);
      check("rst_pkts", 64'(rx_pkts[31:0]), 64'd0);
      check("rst_unknown", 64'(unknown_pkts), 64'd0);
      check("rst_evt", 64'(evt_valid), 64'd0);
      tick();

      // Good flow 0 frame, 3 full beats.
      send_frame(DM[0], SM[0], ET[0], PL[0], 192, -1, 1'b0, 1'b0);
      repeat (2) tick();
      expect_evt("f0_good", 0, 1'b1, 1'b1, 1'b1);
      check("f0_pkts", 64'(rx_pkts[31:0]), 64'd1);
      check("f0_bytes", 64'(rx_bytes[47:0]), 64'd192);

      // Same frame with byte 100 corrupted.
      send_frame(DM[0], SM[0], ET[0], PL[0], 192, 100, 1'b0, 1'b0);
      repeat (2) tick();
      expect_evt("f0_bad", 0, 1'b0, 1'b1, 1'b1);
      check("f0_errs", 64'(rx_errs[31:0]), 64'd1);
      check("f0_pkts_hold", 64'(rx_pkts[31:0]), 64'd1);

      // Flow 2 one byte short.
      send_frame(DM[2], SM[2], ET[2], PL[2], 191, -1, 1'b0, 1'b0);
      repeat (2) tick();
      expect_evt("f2_short", 2, 1'b0, 1'b1, 1'b0);
      check("f2_errs", 64'(rx_errs[95:64]), 64'd1);
      check("f2_pkts", 64'(rx_pkts[95:64]), 64'd0);

      // Unknown dest MAC, then a runt that carries a known dest MAC.
      send_frame(48'h112233445566, SM[0], ET[0], PL[0], 192, -1, 1'b0, 1'b0);
      repeat (2) tick();
      expect_evt("unk_mac", 0, 1'b0, 1'b0, 1'b0);
      send_frame(DM[0], SM[0], ET[0], PL[0], 10, -1, 1'b0, 1'b0);
      repeat (2) tick();
      expect_evt("runt", 0, 1'b0, 1'b0, 1'b0);
      check("unknown_cnt", 64'(unknown_pkts), 64'd2);

      // Standalone clear.
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
      check("clr_pkts0", 64'(rx_pkts[31:0]), 64'd0);
      check("clr_errs0", 64'(rx_errs[31:0]), 64'd0);
      check("clr_unknown", 64'(unknown_pkts), 64'd0);

      // Four back-to-back frames, tvalid held high throughout.
      for (int f = 0; f < 4; f++)
         send_frame(DM[f], SM[f], ET[f], PL[f], SZ[f], -1, 1'b0, (f != 3));
      repeat (2) tick();
      check("b2b_count", 64'(evq.size()), 64'd4);
      if (evq.size() == 4) begin
         for (int f = 0; f < 4; f++) begin
            bb[f] = evq.pop_front();
            check($sformatf("b2b%0d_flow", f), 64'(bb[f].flow), 64'(f));
            check($sformatf("b2b%0d_ok", f), 64'(bb[f].ok), 64'd1);
         end
         check("b2b_gap01", 64'(bb[1].cyc - bb[0].cyc), 64'd1);
         check("b2b_gap12", 64'(bb[2].cyc - bb[1].cyc), 64'd3);
         check("b2b_gap23", 64'(bb[3].cyc - bb[2].cyc), 64'd2);
      end
      for (int f = 0; f < 4; f++) begin
         check($sformatf("b2b_pkts%0d", f), 64'(rx_pkts[32*f +: 32]), 64'd1);
         check($sformatf("b2b_bytes%0d", f), 64'(rx_bytes[48*f +: 48]), 64'(SZ[f]));
      end

      // clear on the same edge as a frame's counter update.
      send_frame(DM[1], SM[1], ET[1], PL[1], 64, -1, 1'b1, 1'b0);
      repeat (2) tick();
      expect_evt("clr_coinc", 1, 1'b1, 1'b1, 1'b1);
      check("clr_coinc_pkts1", 64'(rx_pkts[63:32]), 64'd0);
      check("clr_coinc_bytes1", 64'(rx_bytes[95:48]), 64'd0);
      check("clr_coinc_pkts0", 64'(rx_pkts[31:0]), 64'd0);

      // Reset mid-frame, then a fresh frame.
      axis_tdata  = beat_data(DM[0], SM[0], ET[0], PL[0], 0, -1);
      axis_tkeep  = '1;
      axis_tlast  = 1'b0;
      axis_tvalid = 1'b1;
      tick();
      axis_tvalid = 1'b0;
      rst = 1'b1;
      repeat (2) tick();
      check("tready_mid_rst", 64'(axis_tready), 64'd0);
      rst = 1'b0;
      tick();
      send_frame(DM[3], SM[3], ET[3], PL[3], 128, -1, 1'b0, 1'b0);
      repeat (2) tick();
      expect_evt("post_rst", 3, 1'b1, 1'b1, 1'b1);
      check("post_rst_pkts3", 64'(rx_pkts[127:96]), 64'd1);
      check("post_rst_bytes3", 64'(rx_bytes[191:144]), 64'd128);
      check("post_rst_errs0", 64'(rx_errs[31:0]), 64'd0);
      check("no_extra_evt", 64'(evq.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
